// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and word/address typedefs for regfile_sb
package regfile_pkg;
    localparam int DEF_WORDSIZE = 64;
    localparam int DEF_SIZE = 32;
    function automatic int addr_w(input int size);
        return $clog2(size);
    endfunction
    typedef logic [DEF_WORDSIZE-1:0] word_t;
    typedef logic [addr_w(DEF_SIZE)-1:0] reg_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read mux with optional same-cycle write bypass
module rf_read_port import regfile_pkg::*; #(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int SIZE = DEF_SIZE,
    parameter int BYPASS = 1,
    localparam int ADDRW = addr_w(SIZE)
) (
    input logic [ADDRW-1:0] addr,
    input logic write_en,
    input logic [ADDRW-1:0] write_addr,
    input logic [WORDSIZE-1:0] write_data,
    input logic [SIZE-1:0][WORDSIZE-1:0] regs,
    input logic [SIZE-1:0] busy,
    output logic [WORDSIZE-1:0] data,
    output logic pending
);
    logic zero, hit;
    always_comb begin
        zero = addr == '0;
        hit = BYPASS != 0 && write_en && write_addr == addr && !zero;
        data = zero ? '0 : hit ? write_data : regs[addr];
        pending = !zero && !hit && busy[addr];
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NREAD-port register file with hardwired x0, write bypass and busy scoreboard
module regfile_sb import regfile_pkg::*; #(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int SIZE = DEF_SIZE,
    parameter int NREAD = 2,
    parameter int BYPASS = 1,
    localparam int ADDRW = addr_w(SIZE)
) (
    input logic clk,
    input logic reset,
    input logic write_en,
    input logic [ADDRW-1:0] write_addr,
    input logic [WORDSIZE-1:0] write_data,
    input logic issue_en,
    input logic [ADDRW-1:0] issue_addr,
    input logic [NREAD*ADDRW-1:0] rd_addr,
    output logic [NREAD*WORDSIZE-1:0] rd_data,
    output logic [NREAD-1:0] rd_busy,
    output logic any_busy
);
    logic [SIZE-1:0][WORDSIZE-1:0] regs;
    logic [SIZE-1:0] busy;
    // issue update comes last so a same-address issue overrides the write's busy clear
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (write_en && write_addr != '0) begin
                regs[write_addr] <= write_data;
                busy[write_addr] <= 1'b0;
            end
            if (issue_en && issue_addr != '0)
                busy[issue_addr] <= 1'b1;
        end
    end
    assign any_busy = |busy;
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        rf_read_port #(
            .WORDSIZE(WORDSIZE),
            .SIZE(SIZE),
            .BYPASS(BYPASS)
        ) u_port (
            .addr(rd_addr[k*ADDRW +: ADDRW]),
            .write_en(write_en),
            .write_addr(write_addr),
            .write_data(write_data),
            .regs(regs),
            .busy(busy),
            .data(rd_data[k*WORDSIZE +: WORDSIZE]),
            .pending(rd_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb (3 ports, 16 regs) with bypass and non-bypass instances
module tb_regfile_sb;
    import regfile_pkg::*;
    logic clk = 1'b0;
    logic reset, write_en, issue_en;
    logic [3:0] write_addr, issue_addr;
    logic [63:0] write_data;
    logic [11:0] rd_addr;
    logic [191:0] rd_data, nb_data;
    logic [2:0] rd_busy, nb_busy;
    logic any_busy, nb_any;
    int n_run = 0;
    int n_fail = 0;
    word_t mdl [16];

    regfile_sb #(.WORDSIZE(64), .SIZE(16), .NREAD(3), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .any_busy(any_busy)
    );
    regfile_sb #(.WORDSIZE(64), .SIZE(16), .NREAD(3), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_addr(rd_addr), .rd_data(nb_data), .rd_busy(nb_busy), .any_busy(nb_any)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_run++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] pd(input logic [191:0] v, input int k);
        return v[k*64 +: 64];
    endfunction

    task automatic set_rd(input int k, input int a);
        rd_addr[k*4 +: 4] = 4'(a);
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; issue_en = 1'b0;
        write_addr = '0; issue_addr = '0; write_data = '0; rd_addr = '0;
        tick; tick;
        reset = 1'b0;
        // preload x5 and mark it busy, then reset with competing write/issue
        write_en = 1'b1; write_addr = 4'd5; write_data = 64'hDEAD;
        tick;
        write_en = 1'b0; issue_en = 1'b1; issue_addr = 4'd5; set_rd(0, 5);
        #1 chk("preload_x5", pd(rd_data, 0), 64'hDEAD);
        tick;
        issue_en = 1'b0;
        #1 chk("preload_busy", {63'd0, rd_busy[0]}, 64'd1);
        chk("preload_any", {63'd0, any_busy}, 64'd1);
        reset = 1'b1; write_en = 1'b1; write_data = 64'h1; issue_en = 1'b1; issue_addr = 4'd6;
        tick;
        reset = 1'b0; write_en = 1'b0; issue_en = 1'b0;
        #1 chk("reset_data", pd(rd_data, 0), 64'h0);
        chk("reset_busy", {61'd0, rd_busy}, 64'd0);
        chk("reset_any", {63'd0, any_busy}, 64'd0);
        // x0 is immune to writes and issues, including on the bypass path
        rd_addr = '0;
        write_en = 1'b1; write_addr = 4'd0; write_data = '1; issue_en = 1'b1; issue_addr = 4'd0;
        #1 for (int k = 0; k < 3; k++) chk($sformatf("x0_bypass_p%0d", k), pd(rd_data, k), 64'h0);
        tick;
        write_en = 1'b0; issue_en = 1'b0;
        #1 for (int k = 0; k < 3; k++) chk($sformatf("x0_data_p%0d", k), pd(rd_data, k), 64'h0);
        chk("x0_busy", {61'd0, rd_busy}, 64'd0);
        chk("x0_any", {63'd0, any_busy}, 64'd0);
        // write x3: bypass returns new value same cycle, non-bypass returns old
        set_rd(0, 3); set_rd(1, 3);
        write_en = 1'b1; write_addr = 4'd3; write_data = 64'h1234;
        #1 chk("bypass_p1", pd(rd_data, 1), 64'h1234);
        chk("nobypass_p1", pd(nb_data, 1), 64'h0);
        tick;
        write_en = 1'b0;
        #1 chk("wr_p0", pd(rd_data, 0), 64'h1234);
        chk("wr_nb_p0", pd(nb_data, 0), 64'h1234);
        // scoreboard on x7
        issue_en = 1'b1; issue_addr = 4'd7;
        tick;
        issue_en = 1'b0; set_rd(0, 7);
        #1 chk("x7_busy", {63'd0, rd_busy[0]}, 64'd1);
        chk("x7_any", {63'd0, any_busy}, 64'd1);
        write_en = 1'b1; write_addr = 4'd7; write_data = 64'h55;
        #1 chk("x7_byp_busy", {63'd0, rd_busy[0]}, 64'd0);
        chk("x7_byp_data", pd(rd_data, 0), 64'h55);
        chk("x7_nb_busy", {63'd0, nb_busy[0]}, 64'd1);
        chk("x7_any_nobyp", {63'd0, any_busy}, 64'd1);
        tick;
        write_en = 1'b0;
        #1 chk("x7_done_busy", {63'd0, rd_busy[0]}, 64'd0);
        chk("x7_done_any", {63'd0, any_busy}, 64'd0);
        chk("x7_done_data", pd(rd_data, 0), 64'h55);
        // write and issue the same register: issue wins
        write_en = 1'b1; write_addr = 4'd9; write_data = 64'hAA; issue_en = 1'b1; issue_addr = 4'd9;
        tick;
        write_en = 1'b0; issue_en = 1'b0; set_rd(2, 9);
        #1 chk("coll_data", pd(rd_data, 2), 64'hAA);
        chk("coll_busy", {63'd0, rd_busy[2]}, 64'd1);
        chk("coll_any", {63'd0, any_busy}, 64'd1);
        issue_en = 1'b1; issue_addr = 4'd9;
        tick;
        issue_en = 1'b0;
        #1 chk("reissue_busy", {63'd0, rd_busy[2]}, 64'd1);
        // different addresses in the same cycle both take effect
        write_en = 1'b1; write_addr = 4'd9; write_data = 64'hBB; issue_en = 1'b1; issue_addr = 4'd10;
        tick;
        write_en = 1'b0; issue_en = 1'b0; set_rd(1, 10);
        #1 chk("split_x9_data", pd(rd_data, 2), 64'hBB);
        chk("split_x9_busy", {63'd0, rd_busy[2]}, 64'd0);
        chk("split_x10_busy", {63'd0, rd_busy[1]}, 64'd1);
        chk("split_any", {63'd0, any_busy}, 64'd1);
        // port sweep: fill every register, then read all addresses on all ports
        mdl[0] = '0;
        for (int a = 1; a < 16; a++) begin
            mdl[a] = {$urandom, $urandom};
            write_en = 1'b1; write_addr = 4'(a); write_data = mdl[a];
            tick;
        end
        write_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 3; k++) set_rd(k, (a + k * 5) % 16);
            #1 for (int k = 0; k < 3; k++) begin
                chk($sformatf("sweep_a%0d_p%0d", (a + k * 5) % 16, k), pd(rd_data, k), mdl[(a + k * 5) % 16]);
                chk($sformatf("sweep_nb_a%0d_p%0d", (a + k * 5) % 16, k), pd(nb_data, k), mdl[(a + k * 5) % 16]);
            end
        end
        chk("sweep_busy", {61'd0, rd_busy}, 64'd0);
        chk("sweep_any", {63'd0, any_busy}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
